// File: rtl/serial_carry_adder.sv
// Bit-serial unsigned adder {carry, sum} = a + b + c_in, one full-adder cell reused
// LSB first over WIDTH clocks behind a start/busy/done handshake. Optional SERIAL_CARRY_ADDER_OVF_EN adds ovf.
module serial_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, work;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             accept, last_bit, s_bit, cy_nx;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ cy;
    assign cy_nx    = (a_sh[0] & b_sh[0]) | (a_sh[0] & cy) | (b_sh[0] & cy);

    // NOTE: state and data registers use non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: all datapath flops, shift registers included, are reset so an
    // aborted operation leaves no stale X or partial value behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            work  <= '0;
            cnt   <= '0;
            cy    <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_CARRY_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cy   <= c_in;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            work <= {s_bit, work[WIDTH-1:1]};
            cy   <= cy_nx;
            cnt  <= cnt + CW'(1);
            // Result registers move only here, so partial sums are never visible.
            if (last_bit) begin
                sum   <= {s_bit, work[WIDTH-1:1]};
                carry <= cy_nx;
`ifdef SERIAL_CARRY_ADDER_OVF_EN
                ovf   <= cy ^ cy_nx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_carry_adder.sv
// Self-checking bench for serial_carry_adder (WIDTH=4): directed cases plus randomized
// operations against an arithmetic reference model; ovf checked when SERIAL_CARRY_ADDER_OVF_EN is set.
module tb_serial_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         c_in = 1'b0;
    logic         busy, done, carry;
    logic [W-1:0] sum;
`ifdef SERIAL_CARRY_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Expected held result registers.
    logic [W-1:0] exp_sum   = '0;
    logic         exp_carry = 1'b0;
    logic         exp_ovf   = 1'b0;

    serial_carry_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
`ifdef SERIAL_CARRY_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag);
        check({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " carry"}, 32'(carry), 32'(exp_carry));
`ifdef SERIAL_CARRY_ADDER_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    // One operation from E0 to the completion edge; ends in the done cycle.
    // pulse: cycle index (1..W) at which start is re-asserted while busy, 0 = none.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input int pulse);
        logic [W:0] total;
        start = 1'b1; a = xa; b = xb; c_in = xc;
        tick();
        start = 1'b0;
        check("e0 busy", 32'(busy), 32'd1);
        check("e0 done", 32'(done), 32'd0);
        for (int i = 1; i <= W; i++) begin
            start = (i == pulse);
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            if (i < W) begin
                tick();
                check("run busy", 32'(busy), 32'd1);
                check("run done", 32'(done), 32'd0);
                check_held("run held");
            end
        end
        start = 1'b0;
        tick();
        total     = (W+1)'(xa) + (W+1)'(xb) + (W+1)'(xc);
        exp_sum   = total[W-1:0];
        exp_carry = total[W];
        exp_ovf   = (xa[W-1] == xb[W-1]) && (total[W-1] != xa[W-1]);
        check("cmp done", 32'(done), 32'd1);
        check("cmp busy", 32'(busy), 32'd0);
        check_held("cmp");
    endtask

    task automatic idle_check(input string tag);
        tick();
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check_held(tag);
    endtask

    initial begin
        // Reset state.
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check_held("rst");
        tick();
        tick();
        rst = 1'b0;
        idle_check("post rst");

        // 1. zero operands, busy exactly W cycles.
        run_op(4'd0, 4'd0, 1'b0, 0);
        idle_check("t1 idle");

        // 2. wrap-around carries.
        run_op(4'd15, 4'd1, 1'b0, 0);
        idle_check("t2a idle");
        run_op(4'd9, 4'd6, 1'b1, 0);
        idle_check("t2b idle");

        // 3. start re-pulsed while busy: single done.
        run_op(4'd5, 4'd3, 1'b1, 2);
        idle_check("t3 no extra done");

        // 4. back-to-back: start in the done cycle; prior result held meanwhile.
        run_op(4'd4, 4'd4, 1'b0, 0);
        run_op(4'd2, 4'd3, 1'b0, 0);
        idle_check("t4 idle");

        // 5. reset mid-operation aborts.
        start = 1'b1; a = 4'd6; b = 4'd6; c_in = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        exp_sum = '0; exp_carry = 1'b0; exp_ovf = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check_held("abort");
        tick();
        rst = 1'b0;
        for (int i = 0; i < W + 1; i++) idle_check("abort no done");
        run_op(4'd7, 4'd8, 1'b0, 0);
        idle_check("t5 idle");

`ifdef SERIAL_CARRY_ADDER_OVF_EN
        // 6. signed overflow flag.
        run_op(4'd7, 4'd1, 1'b0, 0);
        check("ovf 7+1", 32'(ovf), 32'd1);
        run_op(4'd8, 4'd8, 1'b0, 0);
        check("ovf 8+8", 32'(ovf), 32'd1);
        run_op(4'd3, 4'd2, 1'b0, 0);
        check("ovf 3+2", 32'(ovf), 32'd0);
        idle_check("t6 idle");
`endif

        // Randomized operations with random gaps and stray start pulses.
        for (int n = 0; n < 60; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, W)));
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_check("rand gap");
        end
        run_op(4'd15, 4'd15, 1'b1, 0);
        idle_check("max idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
